// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU execute stage: alucontrol encodings,
// FSM state type and the bit positions of C and Z within a {C,Z} flag pair.
package alu_pkg;

  localparam logic [2:0] ALU_NDU = 3'b000;
  localparam logic [2:0] ALU_NDZ = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_ADC = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;

  // {C,Z} packing used by flag_in
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: {cout, y} = f(op, a, b).
// Any code that is not NAND or SUB falls through to ADD.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  logic [WIDTH:0] ext;

  // Select the WIDTH+1-bit sum, NAND or difference
  always_comb begin
    ext = {1'b0, a} + {1'b0, b};
    case (op)
      ALU_NDU, ALU_NDZ: ext = {1'b0, ~(a & b)};
      ALU_SUB:          ext = {1'b0, a} - {1'b0, b};
      default:          ext = {1'b0, a} + {1'b0, b};
    endcase
  end

  assign y    = ext[WIDTH-1:0];
  assign cout = ext[WIDTH];

endmodule

// File: rtl/alu_flag_unit.sv
// Multicycle execute stage (IDLE -> EXEC -> DONE) owning the C and Z flags and
// resolving conditional ADC/NDZ writeback. Optional macro ALU_ILLEGAL_TRAP_EN adds
// the illegal_op output and suppresses writeback/flags for undefined codes.
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flag_we,
  input  logic [1:0]       flag_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             reg_we,
  output logic             eq,
  output logic             carry,
`ifdef ALU_ILLEGAL_TRAP_EN
  output logic             illegal_op,
`endif
  output logic             zero
);

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_q;
  logic             cout_q, we_q, eq_q, upd_c_q, upd_z_q;
  logic             c_q, z_q;
  logic [WIDTH-1:0] core_y;
  logic             core_cout;
  logic             is_nand, is_sub, cond_ok, illegal, executes;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .y   (core_y),
    .cout(core_cout)
  );

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Operand latch on accepted start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (state_q == S_IDLE && start) begin
      op_q <= alucontrol;
      a_q  <= srca;
      b_q  <= srcb;
    end
  end

  // Condition/legality decode; C/Z are read as held during EXEC
  always_comb begin
    is_nand = (op_q == ALU_NDU) || (op_q == ALU_NDZ);
    is_sub  = (op_q == ALU_SUB);
    cond_ok = 1'b1;
    if (op_q == ALU_ADC) cond_ok = c_q;
    if (op_q == ALU_NDZ) cond_ok = z_q;
`ifdef ALU_ILLEGAL_TRAP_EN
    illegal = !(is_nand || is_sub || op_q == ALU_ADD || op_q == ALU_ADC);
`else
    illegal = 1'b0;
`endif
    executes = cond_ok && !is_sub && !illegal;
  end

  // Capture the EXEC-cycle result and writeback/flag decisions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q   <= '0;
      cout_q  <= 1'b0;
      we_q    <= 1'b0;
      eq_q    <= 1'b0;
      upd_c_q <= 1'b0;
      upd_z_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      res_q   <= core_y;
      cout_q  <= core_cout;
      we_q    <= executes;
      eq_q    <= is_sub && (core_y == '0);
      upd_c_q <= executes && !is_nand;
      upd_z_q <= executes;
    end
  end

  // Architectural flags; an external load beats the DONE-edge update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else if (flag_we) begin
      c_q <= flag_in[FLAG_C];
      z_q <= flag_in[FLAG_Z];
    end else if (state_q == S_DONE) begin
      if (upd_c_q) c_q <= cout_q;
      if (upd_z_q) z_q <= (res_q == '0);
    end
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  logic ill_q;

  // Latch the trap indication for the DONE pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                ill_q <= 1'b0;
    else if (state_q == S_EXEC)  ill_q <= illegal;
  end

  assign illegal_op = (state_q == S_DONE) && ill_q;
`endif

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign reg_we = done && we_q;
  assign eq     = done && eq_q;
  assign carry  = c_q;
  assign zero   = z_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Self-checking bench for alu_flag_unit: directed scenarios plus randomized ops
// compared against a behavioural model of the flag/condition rules.
module tb_alu_flag_unit;

  localparam int unsigned W = 16;
`ifdef ALU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   alucontrol = '0;
  logic [W-1:0] srca = '0, srcb = '0;
  logic         flag_we = 1'b0;
  logic [1:0]   flag_in = '0;
  logic         busy, done, reg_we, eq, carry, zero;
  logic [W-1:0] result;
  logic         ill_obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_flag_unit #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .alucontrol(alucontrol),
    .srca      (srca),
    .srcb      (srcb),
    .flag_we   (flag_we),
    .flag_in   (flag_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .reg_we    (reg_we),
    .eq        (eq),
    .carry     (carry),
`ifdef ALU_ILLEGAL_TRAP_EN
    .illegal_op(ill_obs),
`endif
    .zero      (zero)
  );

`ifndef ALU_ILLEGAL_TRAP_EN
  assign ill_obs = 1'b0;
`endif

  // Behavioural reference: plain arithmetic on the opcode semantics
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, b,
                                input logic c, z, output logic [W-1:0] r,
                                output logic we, output logic e, output logic il,
                                output logic rchk, output logic nc, output logic nz);
    longint unsigned s;
    r = '0; we = 0; e = 0; il = 0; rchk = 1; nc = c; nz = z;
    if (op == 3'd0 || op == 3'd1) begin
      r  = ~(a & b);
      we = (op == 3'd1) ? z : 1'b1;
      if (we) nz = (r == 0);
    end else if (op == 3'd6) begin
      r = W'((longint'(a) - longint'(b)) & ((64'd1 << W) - 1));
      e = (r == 0);
    end else if (TRAP && op != 3'd2 && op != 3'd3) begin
      il = 1; rchk = 0;
    end else begin
      s  = longint'(a) + longint'(b);
      r  = W'(s % (64'd1 << W));
      we = (op == 3'd3) ? c : 1'b1;
      if (we) begin
        nc = (s >= (64'd1 << W));
        nz = (r == 0);
      end
    end
  endfunction

  task automatic set_flags(input logic [1:0] f);
    flag_we = 1; flag_in = f;
    @(posedge clk); #1;
    flag_we = 0;
  endtask

  // Issue one op from IDLE and collect what the DUT shows at done and after it
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, b,
                       input logic fwe, input logic [1:0] fin,
                       output logic [W-1:0] r, output logic we, output logic e,
                       output logic il, output logic [1:0] cz, output int lat,
                       output logic bsy, output logic done_after);
    alucontrol = op; srca = a; srcb = b; start = 1;
    @(posedge clk); #1;
    start = 0;
    alucontrol = 3'($urandom); srca = W'($urandom); srcb = W'($urandom);
    bsy = busy;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 8);
    r = result; we = reg_we; e = eq; il = ill_obs;
    if (fwe) begin
      flag_we = 1; flag_in = fin;
    end
    @(posedge clk); #1;
    flag_we = 0;
    cz = {carry, zero};
    done_after = done;
  endtask

  task automatic test_reset;
    reset_n = 0;
    #12;
    checks++;
    if ({busy, done, reg_we, eq, ill_obs} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, reg_we, eq, ill_obs});
    end
    checks++;
    if (result !== '0) begin
      errors++; $display("FAIL reset_result got %h want 0000", result);
    end
    checks++;
    if ({carry, zero} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got %b want 00", {carry, zero});
    end
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_wrap;
    logic [W-1:0] r; logic we, e, il, bsy, da; logic [1:0] cz; int lat;
    do_op(3'b010, 16'hFFFF, 16'h0001, 0, 2'b00, r, we, e, il, cz, lat, bsy, da);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
    checks++;
    if (bsy !== 1'b1) begin errors++; $display("FAIL add_busy got %b want 1", bsy); end
    checks++;
    if (r !== 16'h0000 || we !== 1'b1) begin
      errors++; $display("FAIL add_wrap got r=%h we=%b want r=0000 we=1", r, we);
    end
    checks++;
    if (cz !== 2'b11) begin errors++; $display("FAIL add_flags got %b want 11", cz); end
    checks++;
    if (da !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b want 0", da); end
  endtask

  task automatic test_adc_skip;
    logic [W-1:0] r; logic we, e, il, bsy, da; logic [1:0] cz; int lat;
    set_flags(2'b00);
    do_op(3'b011, 16'h0003, 16'h0004, 0, 2'b00, r, we, e, il, cz, lat, bsy, da);
    checks++;
    if (r !== 16'h0007 || we !== 1'b0) begin
      errors++; $display("FAIL adc_skip got r=%h we=%b want r=0007 we=0", r, we);
    end
    checks++;
    if (cz !== 2'b00) begin errors++; $display("FAIL adc_skip_flags got %b want 00", cz); end
  endtask

  task automatic test_ndz;
    logic [W-1:0] r; logic we, e, il, bsy, da; logic [1:0] cz; int lat;
    set_flags(2'b11);
    do_op(3'b001, 16'h00FF, 16'hFF0F, 0, 2'b00, r, we, e, il, cz, lat, bsy, da);
    checks++;
    if (r !== 16'hFFF0 || we !== 1'b1) begin
      errors++; $display("FAIL ndz got r=%h we=%b want r=fff0 we=1", r, we);
    end
    checks++;
    if (cz !== 2'b10) begin errors++; $display("FAIL ndz_flags got %b want 10", cz); end
  endtask

  task automatic test_sub;
    logic [W-1:0] r; logic we, e, il, bsy, da; logic [1:0] cz; int lat;
    set_flags(2'b10);
    do_op(3'b110, 16'h0005, 16'h0005, 0, 2'b00, r, we, e, il, cz, lat, bsy, da);
    checks++;
    if (e !== 1'b1 || we !== 1'b0 || r !== 16'h0000) begin
      errors++; $display("FAIL sub_eq got eq=%b we=%b r=%h want eq=1 we=0 r=0000", e, we, r);
    end
    checks++;
    if (cz !== 2'b10) begin errors++; $display("FAIL sub_flags got %b want 10", cz); end
    do_op(3'b110, 16'h0005, 16'h0006, 0, 2'b00, r, we, e, il, cz, lat, bsy, da);
    checks++;
    if (e !== 1'b0 || r !== 16'hFFFF) begin
      errors++; $display("FAIL sub_ne got eq=%b r=%h want eq=0 r=ffff", e, r);
    end
  endtask

  task automatic test_start_ignored;
    int ndone;
    alucontrol = 3'b010; srca = 16'h1234; srcb = 16'h1111; start = 1;
    @(posedge clk); #1;
    // now in EXEC: this start must not be queued
    @(posedge clk); #1;
    start = 0;
    ndone = 0;
    if (done) ndone++;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL start_busy_dones got %0d want 1", ndone); end
    // reset during EXEC
    alucontrol = 3'b010; srca = 16'hAAAA; srcb = 16'h5555; start = 1;
    @(posedge clk); #1;
    start = 0;
    reset_n = 0;
    #1;
    checks++;
    if ({busy, done, reg_we, eq, carry, zero} !== 6'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_exec got ctrl=%b r=%h want ctrl=000000 r=0000",
               {busy, done, reg_we, eq, carry, zero}, result);
    end
    @(negedge clk);
    reset_n = 1;
    ndone = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL reset_exec_done got %0d want 0", ndone); end
  endtask

  task automatic test_illegal;
    logic [W-1:0] r, er; logic we, e, il, bsy, da, ewe, ee, eil, rchk, nc, nz;
    logic [1:0] cz; int lat; logic [W-1:0] a, b;
    a = W'($urandom); b = W'($urandom);
    set_flags(2'b01);
    model(3'b111, a, b, 1'b0, 1'b1, er, ewe, ee, eil, rchk, nc, nz);
    do_op(3'b111, a, b, 0, 2'b00, r, we, e, il, cz, lat, bsy, da);
    checks++;
    if (il !== eil || we !== ewe) begin
      errors++; $display("FAIL illegal got il=%b we=%b want il=%b we=%b", il, we, eil, ewe);
    end
    checks++;
    if (rchk && r !== er) begin
      errors++; $display("FAIL illegal_result got %h want %h", r, er);
    end
    checks++;
    if (cz !== {nc, nz}) begin
      errors++; $display("FAIL illegal_flags got %b want %b", cz, {nc, nz});
    end
  endtask

  task automatic test_flag_collision;
    logic [W-1:0] r; logic we, e, il, bsy, da; logic [1:0] cz; int lat;
    set_flags(2'b00);
    do_op(3'b010, 16'hFFFF, 16'h0001, 1, 2'b01, r, we, e, il, cz, lat, bsy, da);
    checks++;
    if (cz !== 2'b01) begin errors++; $display("FAIL flag_collision got %b want 01", cz); end
  endtask

  // Randomized back-to-back ops; each start is issued the cycle after DONE
  task automatic test_back_to_back;
    logic [W-1:0] r, er, a, b; logic we, e, il, bsy, da, ewe, ee, eil, rchk, nc, nz;
    logic [1:0] cz; logic [2:0] op; int lat;
    logic cm, zm;
    set_flags(2'($urandom));
    cm = carry; zm = zero;
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      if (($urandom % 4) == 0) op = 3'b011;
      if (($urandom % 4) == 0) op = 3'b001;
      a = W'($urandom); b = W'($urandom);
      if (($urandom % 8) == 0) b = a;
      if (($urandom % 8) == 0) b = W'(-a);
      model(op, a, b, cm, zm, er, ewe, ee, eil, rchk, nc, nz);
      do_op(op, a, b, 0, 2'b00, r, we, e, il, cz, lat, bsy, da);
      checks++;
      if (lat !== 1 || bsy !== 1'b1 || da !== 1'b0) begin
        errors++;
        $display("FAIL rnd_timing[%0d] got lat=%0d busy=%b done_after=%b want 1 1 0",
                 i, lat, bsy, da);
      end
      checks++;
      if ((rchk && r !== er) || we !== ewe || e !== ee || il !== eil) begin
        errors++;
        $display("FAIL rnd_out[%0d] op=%b a=%h b=%h got r=%h we=%b eq=%b il=%b want r=%h we=%b eq=%b il=%b",
                 i, op, a, b, r, we, e, il, er, ewe, ee, eil);
      end
      checks++;
      if (cz !== {nc, nz}) begin
        errors++; $display("FAIL rnd_flags[%0d] op=%b got %b want %b", i, op, cz, {nc, nz});
      end
      cm = nc; zm = nz;
    end
  endtask

  initial begin
    test_reset;
    test_add_wrap;
    test_adc_skip;
    test_ndz;
    test_sub;
    test_start_ignored;
    test_illegal;
    test_flag_collision;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
